sump_cmd_parser: RTL
====================

// Module: sump_cmd_parser
// PURPOSE
//  Receive side of the SUMP host command protocol. Assembles the byte stream from the
//  serial/SPI receiver into opcode + 32-bit config_data and pulses execute toward the
//  analyzer core. A short command is 1 byte, opcode[7]=0. A long command is 5 bytes,
//  opcode[7]=1, followed by 4 data bytes sent LSB first. A long command whose bytes stop
//  arriving is abandoned by an inter-byte timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  24'd1000000  max clock cycles allowed between bytes of one long command
// PORTS
//  clock        in   1   system clock; the only clock
//  reset        in   1   synchronous, active-high reset
//  rx_valid     in   1   rx_data valid this cycle; one byte accepted per asserted cycle
//  rx_data      in   8   received byte
//  opcode       out  8   opcode of the last completed command
//  config_data  out  32  data of the last completed long command; 0 for short commands
//  execute      out  1   1-cycle pulse: opcode/config_data valid
//  busy         out  1   high while a long command is partially received
//  cmd_timeout  out  1   1-cycle pulse: partial long command discarded
// BEHAVIOUR
//  Reset values: opcode=8'h00, config_data=32'h0, execute=0, busy=0, cmd_timeout=0,
//   state=IDLE, byte index=0, timeout counter=0.
//  Every byte is accepted; there is no backpressure. All outputs are registered.
//  FSM states: IDLE, LONG(idx 0..3).
//   IDLE, rx_valid, rx_data[7]=0:
//    - next cycle: opcode=rx_data, config_data=0, execute=1.
//    - state stays IDLE.
//   IDLE, rx_valid, rx_data[7]=1:
//    - latch rx_data into a shadow opcode; clear shadow data.
//    - idx=0, go to LONG, busy=1 from the next cycle.
//   LONG, rx_valid:
//    - shadow_data[8*idx +: 8] = rx_data; clear timeout counter.
//    - idx<3: idx++.
//    - idx==3: next cycle opcode=shadow opcode, config_data=full 32-bit value,
//      execute=1, busy=0, state=IDLE.
//   LONG, !rx_valid: increment the timeout counter.
//    - When the counter reaches TIMEOUT_CYCLES-1, go to IDLE the next cycle:
//      cmd_timeout=1, busy=0, execute stays 0, opcode/config_data unchanged.
//  Latency: execute is asserted exactly 1 cycle after the cycle the final byte is accepted.
//  opcode and config_data update only when execute pulses and hold until the next execute.
//  A timeout never alters them.
//  Boundary conditions:
//   - rx_valid on the cycle the timeout would expire: the byte wins and the counter clears.
//   - Bytes on consecutive cycles: each is accepted. A new command byte in the cycle
//     execute is high is processed normally, so back-to-back execute pulses are legal.
//   - The timeout counter is 24 bits, saturating. TIMEOUT_CYCLES=0 is illegal;
//     TIMEOUT_CYCLES=1 gives a timeout on the first idle cycle.
//   - Reset in any state, including mid long command: the partial command is discarded,
//     all reset values are restored, and no execute or cmd_timeout pulse is emitted.
//   - Five 8'h00 bytes (host reset sequence) produce five short executes with opcode 8'h00.
//   - In IDLE the timeout counter is held at 0.
// TESTING
//  1 Short: rx 8'h01 -> next cycle execute=1, opcode=8'h01, config_data=0; busy never set.
//  2 Long: rx 8'h80,8'h78,8'h56,8'h34,8'h12 spaced 3 cycles -> one execute, opcode=8'h80,
//    config_data=32'h12345678; busy high from the cycle after 8'h80 until execute.
//  3 Timeout (TIMEOUT_CYCLES=16): rx 8'hC0,8'hAA, then idle -> cmd_timeout pulses 16 cycles
//    after the 8'hAA byte; no execute; opcode/config_data keep previous values; then
//    rx 8'h02 -> short execute.
//  4 Race (TIMEOUT_CYCLES=16): 8'h81 then a data byte exactly on the expiry cycle -> no
//    timeout; command completes when the remaining 3 bytes arrive.
//  5 Reset mid-command: rx 8'h82,8'h11, assert reset 1 cycle -> all outputs 0; then
//    8'h83 + 4 bytes -> config_data built only from the new bytes.
//  6 Back-to-back: 8'h00 x5 on consecutive cycles -> 5 consecutive execute pulses;
//    then 8'h81 + 4 bytes with no gaps -> execute 1 cycle after the 5th byte.

Source files
------------

// File: rtl/sump_cmd_parser.sv
// sump_cmd_parser
//   Receive side of the SUMP host command protocol. Bytes from the serial/SPI
//   receiver are assembled into an opcode plus a 32-bit config word, and a
//   single-cycle execute pulse tells the analyzer core that both are valid.
//   Short commands are one byte (bit 7 clear). Long commands are five bytes
//   (bit 7 set), made of the opcode followed by four data bytes, LSB first.
//   A long command that stalls for TIMEOUT_CYCLES idle cycles is dropped.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   rx_valid     in   rx_data holds a byte this cycle (always accepted)
//   rx_data      in   received byte
//   opcode       out  opcode of the last completed command
//   config_data  out  data of the last completed long command, 0 after a short one
//   execute      out  1-cycle pulse: opcode/config_data updated
//   busy         out  a long command is partially received
//   cmd_timeout  out  1-cycle pulse: a partial long command was discarded
module sump_cmd_parser #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic [7:0]  opcode,
   output logic [31:0] config_data,
   output logic        execute,
   output logic        busy,
   output logic        cmd_timeout
);

   typedef enum logic {IDLE, LONG} state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  sop_q, sop_d;
   logic [31:0] sdata_q, sdata_d;
   logic [23:0] cnt_q, cnt_d;
   logic [7:0]  opcode_d;
   logic [31:0] cfg_d;
   logic        exec_d, busy_d, to_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         sop_q       <= 8'h00;
         sdata_q     <= 32'h0;
         cnt_q       <= 24'd0;
         opcode      <= 8'h00;
         config_data <= 32'h0;
         execute     <= 1'b0;
         busy        <= 1'b0;
         cmd_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sop_q       <= sop_d;
         sdata_q     <= sdata_d;
         cnt_q       <= cnt_d;
         opcode      <= opcode_d;
         config_data <= cfg_d;
         execute     <= exec_d;
         busy        <= busy_d;
         cmd_timeout <= to_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sop_d    = sop_q;
      sdata_d  = sdata_q;
      cnt_d    = cnt_q;
      opcode_d = opcode;
      cfg_d    = config_data;
      exec_d   = 1'b0;
      busy_d   = busy;
      to_d     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = 24'd0;
            if (rx_valid) begin
               if (!rx_data[7]) begin
                  opcode_d = rx_data;
                  cfg_d    = 32'h0;
                  exec_d   = 1'b1;
               end else begin
                  sop_d   = rx_data;
                  sdata_d = 32'h0;
                  idx_d   = 2'd0;
                  state_d = LONG;
                  busy_d  = 1'b1;
               end
            end
         end
         LONG: begin
            if (rx_valid) begin
               // A byte arriving on the expiry cycle takes priority over the timeout.
               sdata_d[{idx_q, 3'b000} +: 8] = rx_data;
               cnt_d = 24'd0;
               if (idx_q == 2'd3) begin
                  opcode_d = sop_q;
                  cfg_d    = sdata_d;
                  exec_d   = 1'b1;
                  busy_d   = 1'b0;
                  idx_d    = 2'd0;
                  state_d  = IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end else if (cnt_q == TIMEOUT_CYCLES - 24'd1) begin
               // Drop the partial command; opcode/config_data are left untouched.
               to_d    = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = 24'd0;
               idx_d   = 2'd0;
               state_d = IDLE;
            end else if (cnt_q != 24'hFFFFFF) begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
